// File: rtl/updi_pkg.sv
// Shared definitions for the UPDI transmitter.
// Holds the controller state encoding, frame shape constants and the parity helper.
package updi_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 2;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } updi_state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic parity_even(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/updi_baud_tick.sv
// Bit-time generator for the UPDI transmitter.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset
//   restart - hold the counter at 0; counting starts on the first cycle it is low
//   tick    - high on the last cycle of each CLK_DIV-cycle bit time
module updi_baud_tick #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam logic [15:0] LastCnt = 16'(CLK_DIV - 1);

  logic [15:0] cnt_q;

  assign tick = !restart && (cnt_q == LastCnt);

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt_q <= '0;
    end else if (cnt_q == LastCnt) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/updi_tx.sv
// UPDI serial transmitter: pulls bytes from an upstream fifo and sends
// 12-bit frames (start, 8 data LSB first, even parity, 2 stop), or a BREAK.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   fifo_data   - byte from the fifo, valid the cycle after fifo_rd_en
//   fifo_empty  - fifo has no bytes
//   fifo_rd_en  - one-cycle read strobe (only in FETCH)
//   break_req   - single-cycle BREAK request pulse
//   tx          - serial line, idle high (registered)
//   tx_en       - line driver enable (registered)
//   busy        - controller is not idle
module updi_tx
  import updi_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned BREAK_BITS = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic       break_req,
  output logic       tx,
  output logic       tx_en,
  output logic       busy
);

  localparam int unsigned BrkW = $clog2(BREAK_BITS + 1);

  updi_state_e     state_q;
  logic [7:0]      shift_q;
  logic            par_q;
  logic [2:0]      bit_cnt_q;
  logic [BrkW-1:0] brk_cnt_q;
  logic            brk_pend_q;
  logic            tx_q;
  logic            tx_en_q;

  logic restart;
  logic tick;

  // Holding the counter through IDLE/FETCH/LOAD makes it start at 0 on entry
  // to START or BREAK.
  assign restart = (state_q == StIdle) || (state_q == StFetch) || (state_q == StLoad);

  updi_baud_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  assign fifo_rd_en = (state_q == StFetch);
  assign busy       = (state_q != StIdle);
  assign tx         = tx_q;
  assign tx_en      = tx_en_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      par_q      <= 1'b0;
      bit_cnt_q  <= '0;
      brk_cnt_q  <= '0;
      brk_pend_q <= 1'b0;
      tx_q       <= 1'b1;
      tx_en_q    <= 1'b0;
    end else begin
      // Set first so that the clear on BREAK entry below takes priority.
      if (break_req) brk_pend_q <= 1'b1;

      // Line outputs are decoded from the current state, so the line trails
      // the state by one cycle; this keeps tx/tx_en free of input paths.
      tx_q    <= 1'b1;
      tx_en_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          tx_en_q <= 1'b0;
          if (brk_pend_q) begin
            brk_pend_q <= 1'b0;
            brk_cnt_q  <= '0;
            state_q    <= StBreak;
          end else if (!fifo_empty) begin
            state_q <= StFetch;
          end
        end
        StFetch: begin
          tx_en_q <= 1'b0;
          state_q <= StLoad;
        end
        StLoad: begin
          tx_en_q   <= 1'b0;
          shift_q   <= fifo_data;
          par_q     <= parity_even(fifo_data);
          bit_cnt_q <= '0;
          state_q   <= StStart;
        end
        StStart: begin
          tx_q <= 1'b0;
          if (tick) state_q <= StData;
        end
        StData: begin
          tx_q <= shift_q[0];
          if (tick) begin
            shift_q <= shift_q >> 1;
            if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
              bit_cnt_q <= '0;
              state_q   <= StParity;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        StParity: begin
          tx_q <= par_q;
          if (tick) state_q <= StStop;
        end
        StStop: begin
          if (tick) begin
            if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
              bit_cnt_q <= '0;
              state_q   <= StIdle;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        StBreak: begin
          tx_q <= 1'b0;
          if (tick) begin
            if (brk_cnt_q == BrkW'(BREAK_BITS - 1)) begin
              brk_cnt_q <= '0;
              bit_cnt_q <= '0;
              state_q   <= StStop;
            end else begin
              brk_cnt_q <= brk_cnt_q + BrkW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_updi_tx.sv
// Self-checking bench for updi_tx with a behavioural 32x8 fifo upstream.
module tb_updi_tx;

  localparam int unsigned ClkDiv  = 4;
  localparam int unsigned BrkBits = 12;
  localparam int          Limit   = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic       break_req = 1'b0;
  logic       tx;
  logic       tx_en;
  logic       busy;

  // Upstream fifo
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] mem [32];
  logic [4:0] wp = 5'd0;
  logic [4:0] rp = 5'd0;
  int         fcount = 0;
  int         rd_cnt = 0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en && fcount < 32) begin
      mem[wp] <= wr_data;
      wp      <= wp + 5'd1;
    end
    if (fifo_rd_en && fcount > 0) begin
      fifo_data <= mem[rp];
      rp        <= rp + 5'd1;
    end
    fcount <= fcount + ((wr_en && fcount < 32) ? 1 : 0) - ((fifo_rd_en && fcount > 0) ? 1 : 0);
    if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
  end

  assign fifo_empty = (fcount == 0);

  updi_tx #(
    .CLK_DIV   (ClkDiv),
    .BREAK_BITS(BrkBits)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_data (fifo_data),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .break_req (break_req),
    .tx        (tx),
    .tx_en     (tx_en),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0]  data;
    logic [11:0] frame;  // bit i = line value during bit time i
    string       name;
  } vec_t;

  vec_t vecs[5];

  // Reference frame: start, data LSB first, parity making the ones count even, stops.
  function automatic logic [11:0] frame_of(input logic [7:0] d);
    int ones;
    logic [11:0] f;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    f[9]  = logic'(ones % 2);
    f[10] = 1'b1;
    f[11] = 1'b1;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Advance until the line is sampled low; highs = idle-high samples seen.
  task automatic wait_fall(input string name, output int highs);
    int en_bad;
    highs  = 0;
    en_bad = 0;
    @(negedge clk);
    while (tx !== 1'b0 && highs < Limit) begin
      if (tx_en !== 1'b0) en_bad++;
      highs++;
      @(negedge clk);
    end
    if (highs >= Limit) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_fall required=fall", name);
    end
    check({name, "_gap_tx_en"}, en_bad, 0);
  endtask

  // Entered on the first start-bit sample. Optionally injects a break_req
  // (plus a fifo write) at sample inj and a second break_req at inj+20.
  task automatic check_bits(input string name, input logic [11:0] exp, input int inj,
                            input logic [7:0] inj_byte);
    logic [3:0] samp;
    int en_bad;
    int j;
    en_bad = 0;
    j = 0;
    for (int i = 0; i < 12; i++) begin
      for (int c = 0; c < ClkDiv; c++) begin
        if (j > 0) @(negedge clk);
        samp[c] = tx;
        if (tx_en !== 1'b1) en_bad++;
        if (inj >= 0) begin
          if (j == inj) begin
            break_req = 1'b1;
            wr_en     = 1'b1;
            wr_data   = inj_byte;
          end else if (j == inj + 1 || j == inj + 21) begin
            break_req = 1'b0;
            wr_en     = 1'b0;
          end else if (j == inj + 20) begin
            break_req = 1'b1;
          end
        end
        j++;
      end
      check($sformatf("%s_bit%0d", name, i), samp, {4{exp[i]}});
    end
    check({name, "_tx_en"}, en_bad, 0);
  endtask

  // Entered on the first low sample of a BREAK; returns on the first sample after the stops.
  task automatic check_break(input string name);
    int lows;
    int highs;
    int en_bad;
    lows   = 1;
    highs  = 0;
    en_bad = (tx_en !== 1'b1) ? 1 : 0;
    @(negedge clk);
    while (tx === 1'b0 && lows < Limit) begin
      if (tx_en !== 1'b1) en_bad++;
      lows++;
      @(negedge clk);
    end
    while (tx === 1'b1 && tx_en === 1'b1 && highs < Limit) begin
      highs++;
      @(negedge clk);
    end
    check({name, "_low_cycles"}, lows, BrkBits * ClkDiv);
    check({name, "_stop_cycles"}, highs, 2 * ClkDiv);
    check({name, "_low_tx_en"}, en_bad, 0);
    check({name, "_end_tx_en"}, tx_en, 1'b0);
    check({name, "_end_tx"}, tx, 1'b1);
  endtask

  initial begin
    int h;
    int rd0;
    int lows;
    logic [7:0] d;

    vecs[0] = '{data: 8'h55, frame: 12'hCAA, name: "v55"};
    vecs[1] = '{data: 8'h01, frame: 12'hE02, name: "v01"};
    vecs[2] = '{data: 8'hA5, frame: 12'hD4A, name: "vA5"};
    vecs[3] = '{data: 8'hFF, frame: 12'hDFE, name: "vFF"};
    vecs[4] = '{data: 8'h80, frame: 12'hF00, name: "v80"};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_tx_en", tx_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_en", fifo_rd_en, 1'b0);
    rst = 1'b0;

    // Table-driven single frames
    for (int k = 0; k < 5; k++) begin
      rd0 = rd_cnt;
      push(vecs[k].data);
      wait_fall(vecs[k].name, h);
      check_bits(vecs[k].name, vecs[k].frame, -1, 8'h00);
      @(negedge clk);
      check({vecs[k].name, "_busy_after"}, busy, 1'b0);
      check({vecs[k].name, "_tx_after"}, tx, 1'b1);
      check({vecs[k].name, "_rd_pulses"}, rd_cnt - rd0, 1);
    end

    // Random single frames against the model
    for (int k = 0; k < 12; k++) begin
      d = 8'($urandom_range(0, 255));
      push(d);
      wait_fall($sformatf("rnd%0d", k), h);
      check_bits($sformatf("rnd%0d_%02h", k, d), frame_of(d), -1, 8'h00);
    end

    // Burst of 31 bytes: order, 3-cycle gaps, read count
    repeat (5) @(negedge clk);
    rd0 = rd_cnt;
    fork
      begin
        for (int i = 0; i < 31; i++) push(8'(i));
      end
    join_none
    for (int i = 0; i < 31; i++) begin
      wait_fall($sformatf("burst%0d", i), h);
      if (i > 0) check($sformatf("burst%0d_gap", i), h, 3);
      check_bits($sformatf("burst%0d", i), frame_of(8'(i)), -1, 8'h00);
    end
    repeat (4) @(negedge clk);
    check("burst_rd_pulses", rd_cnt - rd0, 31);
    check("burst_fifo_empty", fifo_empty, 1'b1);
    check("burst_busy", busy, 1'b0);

    // BREAK from idle with empty fifo
    @(negedge clk);
    break_req = 1'b1;
    @(negedge clk);
    break_req = 1'b0;
    wait_fall("brk_idle", h);
    check_break("brk_idle");
    @(negedge clk);
    check("brk_idle_busy", busy, 1'b0);

    // Two break_req pulses mid-frame with a byte queued: frame, one BREAK, queued byte
    rd0 = rd_cnt;
    push(8'h3A);
    wait_fall("mid_a", h);
    check_bits("mid_a", frame_of(8'h3A), 10, 8'hC5);
    wait_fall("mid_brk", h);
    check("mid_brk_gap", h, 1);
    check_break("mid_brk");
    wait_fall("mid_b", h);
    check("mid_b_gap", h + 1, 3);
    check_bits("mid_b", frame_of(8'hC5), -1, 8'h00);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("mid_single_break", lows, 0);
    check("mid_rd_pulses", rd_cnt - rd0, 2);

    // Reset during data bit 3, then a clean frame
    push(8'h3C);
    wait_fall("rst_mid", h);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tx", tx, 1'b1);
    check("rst_mid_tx_en", tx_en, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_rd_en", fifo_rd_en, 1'b0);
    rst = 1'b0;
    rd0 = rd_cnt;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_en !== 1'b0) lows++;
    end
    check("rst_quiet_line", lows, 0);
    check("rst_quiet_rd", rd_cnt - rd0, 0);
    push(8'hA5);
    wait_fall("rst_a5", h);
    check_bits("rst_a5", frame_of(8'hA5), -1, 8'h00);
    check("rst_a5_rd", rd_cnt - rd0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/updi_tx.md
UPDI_TX -- requirements
Module: updi_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16: clk cycles per UPDI bit time; legal range 2..65535.
REQ-002 SHALL have parameter BREAK_BITS, default 12: bit times tx is held low for a BREAK.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous reset, active-high.
REQ-005 SHALL have port fifo_data, input, 8: byte from the upstream fifo read port; valid the cycle after fifo_rd_en.
REQ-006 SHALL have port fifo_empty, input, 1: upstream fifo has no bytes.
REQ-007 SHALL have port fifo_rd_en, output, 1: one-cycle read strobe to the upstream fifo.
REQ-008 SHALL have port break_req, input, 1: single-cycle pulse requesting a BREAK.
REQ-009 SHALL have port tx, output, 1: serial line value; idle high.
REQ-010 SHALL have port tx_en, output, 1: line driver enable, high from start or break bit through the last stop bit.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-012 Frame SHALL be: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit (XOR of data), 2 stop bits (1); 12 bit times total.
REQ-013 Each bit SHALL last exactly CLK_DIV cycles, timed by a baud counter that restarts at 0 on entry to START and BREAK.
REQ-014 States SHALL be IDLE, FETCH, LOAD, START, DATA, PARITY, STOP, BREAK.
REQ-015 IDLE: break pending -> BREAK; else fifo_empty=0 -> FETCH; else stay.
REQ-016 FETCH SHALL last one cycle with fifo_rd_en=1, then -> LOAD; fifo_rd_en SHALL be 0 in all other states.
REQ-017 LOAD SHALL capture fifo_data into the shift register, compute parity, -> START.
REQ-018 tx SHALL fall at the third rising edge after the edge at which IDLE samples fifo_empty=0.
REQ-019 START -> DATA after 1 bit time; DATA -> PARITY after 8 bit times (3-bit bit counter); PARITY -> STOP after 1; STOP -> IDLE after 2.
REQ-020 BREAK SHALL drive tx=0 for BREAK_BITS bit times, then -> STOP (2 stop bits high), then IDLE.
REQ-021 break_req SHALL set a pending flag, cleared on entry to BREAK; a request while busy SHALL be serviced at the next IDLE, ahead of any queued byte.
REQ-022 Multiple break_req pulses before service SHALL produce one BREAK.
REQ-023 Back-to-back bytes SHALL be separated by exactly 3 idle-high cycles (IDLE, FETCH, LOAD); fifo_empty changes during a frame SHALL be ignored.
REQ-024 tx and tx_en SHALL be registered outputs (no combinational path from inputs).

Reset
REQ-025 rst SHALL force IDLE, tx=1, tx_en=0, busy=0, fifo_rd_en=0, break pending=0, counters and shift register=0, effective on the next rising edge.
REQ-026 rst mid-frame or mid-BREAK SHALL abort with no further fifo_rd_en; the byte in flight is discarded.

Structure
REQ-027 State enum, frame constants (DATA_BITS=8, STOP_BITS=2) and parity function SHALL live in shared package updi_pkg.
REQ-028 Bit timing SHALL be a sub-module updi_baud_tick (parameter CLK_DIV; ports clk, rst, restart, tick) instantiated once.

Verification
REQ-029 Bench uses CLK_DIV=4 with the team fifo (DEPTH 32, WIDTH 8) upstream.
REQ-030 Write 0x55 -> one fifo_rd_en pulse; tx = 0,1,0,1,0,1,0,1,0,0,1,1, each 4 cycles; busy low after 48 cycles.
REQ-031 Write 0x01 -> parity bit 1; frame 0,1,0,0,0,0,0,0,0,1,1,1.
REQ-032 Write 0x00..0x1E (31 bytes) -> 31 frames in order, 3-cycle gaps, exactly 31 fifo_rd_en pulses, fifo_empty=1 at end.
REQ-033 break_req while idle, fifo empty -> tx low 48 cycles, high 8 cycles with tx_en=1, then IDLE; break_req mid-frame with byte queued -> frame completes, BREAK, then queued byte.
REQ-034 rst during DATA bit 3 -> next edge tx=1, tx_en=0, busy=0; later write 0xA5 -> clean full frame.
